// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: clips a command rectangle to the visible area and
// streams one frame-buffer write per pixel in raster order under src_rdy backpressure.
module vga_rect_fill #(
    parameter int unsigned H_SIZE    = 10,
    parameter int unsigned V_SIZE    = 9,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned RGB_SIZE  = 12,
    parameter int unsigned AVS_DW    = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [H_SIZE-1:0]   cmd_x0,
    input  logic [H_SIZE-1:0]   cmd_x1,
    input  logic [V_SIZE-1:0]   cmd_y0,
    input  logic [V_SIZE-1:0]   cmd_y1,
    input  logic [RGB_SIZE-1:0] cmd_color,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                src_write,
    output logic [H_SIZE-1:0]   src_x,
    output logic [V_SIZE-1:0]   src_y,
    output logic [AVS_DW-1:0]   src_writedata,
    input  logic                src_rdy
);

    localparam logic [H_SIZE-1:0] X_MAX = H_SIZE'(H_DISPLAY - 1);
    localparam logic [V_SIZE-1:0] Y_MAX = V_SIZE'(V_DISPLAY - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

    state_t              state_q, state_d;
    logic                err_q, err_d;
    logic [H_SIZE-1:0]   x0_q, x1_q, x_q;
    logic [V_SIZE-1:0]   y0_q, y1_q, y_q;
    logic [RGB_SIZE-1:0] color_q;
    logic [H_SIZE-1:0]   x1_clip_c;
    logic [V_SIZE-1:0]   y1_clip_c;
    logic                accept_c;
    logic                row_end_c;
    logic                last_c;

    // Clipping is idempotent, so it is safe to re-apply after x1_q/y1_q hold clipped values.
    always_comb begin
        x1_clip_c = (x1_q > X_MAX) ? X_MAX : x1_q;
        y1_clip_c = (y1_q > Y_MAX) ? Y_MAX : y1_q;
        accept_c  = (state_q == FILL) && src_rdy;
        row_end_c = (x_q == x1_q);
        last_c    = accept_c && row_end_c && (y_q == y1_q);
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (cmd_valid) state_d = LOAD;
            end
            LOAD: begin
                if ((x0_q > x1_clip_c) || (y0_q > y1_clip_c)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (last_c) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and status outputs, registered from the next-state decode.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            src_write <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            cmd_ready <= (state_d == IDLE);
            busy      <= (state_d == LOAD) || (state_d == FILL);
            done      <= (state_d == DONE);
            err       <= (state_d == DONE) && err_d;
            src_write <= (state_d == FILL);
        end
    end

    // Command capture, clip latch and raster counters.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            x0_q    <= '0;
            x1_q    <= '0;
            x_q     <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            y_q     <= '0;
            color_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        x0_q    <= cmd_x0;
                        x1_q    <= cmd_x1;
                        y0_q    <= cmd_y0;
                        y1_q    <= cmd_y1;
                        color_q <= cmd_color;
                    end
                end
                LOAD: begin
                    x1_q <= x1_clip_c;
                    y1_q <= y1_clip_c;
                    x_q  <= x0_q;
                    y_q  <= y0_q;
                end
                FILL: begin
                    if (accept_c && !last_c) begin
                        if (row_end_c) begin
                            x_q <= x0_q;
                            y_q <= y_q + V_SIZE'(1);
                        end else begin
                            x_q <= x_q + H_SIZE'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign src_x         = x_q;
    assign src_y         = y_q;
    assign src_writedata = AVS_DW'(color_q);

endmodule
